// File: rtl/shumezuesi_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier that borrows the CPU's
// shared 16-bit adder through add_a/add_b/add_rez/add_cout, one step per cycle.
//
// state | meaning
// IDLE  | waiting for start, ready=1, adder inputs quiet
// RUN   | 16 add/shift steps, one per cycle
// DONE  | one-cycle done pulse, product just loaded
module shumezuesi_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_rez,
    input  logic        add_cout
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]  state;
    logic [15:0] mcand;
    logic [15:0] acc_hi;
    logic [15:0] acc_lo;
    logic [4:0]  cnt;
    logic [32:0] step_full;
    logic [31:0] step_next;

    // Carry from the adder lands in bit 31 after the shift, so nothing is lost.
    assign step_full = {add_cout, add_rez, acc_lo};
    assign step_next = step_full[32:1];

    assign ready = (state == IDLE);
    assign busy  = (state == RUN) || (state == DONE);
    assign done  = (state == DONE);

    always_comb begin
        add_a = 16'h0000;
        add_b = 16'h0000;
        if (state == RUN) begin
            add_a = acc_hi;
            add_b = acc_lo[0] ? mcand : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= 16'h0000;
            acc_hi  <= 16'h0000;
            acc_lo  <= 16'h0000;
            cnt     <= 5'd0;
            product <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        acc_hi <= 16'h0000;
                        acc_lo <= op_b;
                        cnt    <= 5'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    {acc_hi, acc_lo} <= step_next;
                    cnt              <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        product <= step_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
